// File: rtl/fx_ram_arb_pkg.sv
// Shared types and constants for the CPU/DMA RAM arbiter.
// Holds the FSM state encoding, the owner encoding and the default abort limit.
package fx_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int AW = 21;
    localparam int DW = 32;
    localparam int BW = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the requester not granted last wins.
// The last-grant register only moves when the caller takes the grant.
module rr_arb2
    import fx_ram_arb_pkg::*;
(
    input  logic   CLK,
    input  logic   RESn,
    input  logic   CE,
    input  logic   i_req_cpu,
    input  logic   i_req_dma,
    input  logic   i_take,
    output logic   o_valid,
    output owner_t o_owner
);

    owner_t r_last;

    always_comb begin
        o_valid = i_req_cpu | i_req_dma;
        o_owner = OWN_DMA;
        if (i_req_cpu && i_req_dma) begin
            o_owner = (r_last == OWN_DMA) ? OWN_CPU : OWN_DMA;
        end else if (i_req_cpu) begin
            o_owner = OWN_CPU;
        end
    end

    // Resetting to DMA makes the CPU win the first tie after reset.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_last <= OWN_DMA;
        end else if (CE && i_take && o_valid) begin
            r_last <= o_owner;
        end
    end

endmodule

// File: rtl/fx_ram_arb.sv
// Shares one RAM port between a CPU bus and a DMA requester.
// IDLE arbitrates, XFER holds the RAM cycle until ready or timeout, DONE pulses completion.
module fx_ram_arb
    import fx_ram_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          CLK,
    input  logic          RESn,
    input  logic          CE,
    input  logic          CPU_BCYSTn,
    input  logic          CPU_CEn,
    input  logic [AW-1:0] CPU_A,
    input  logic [DW-1:0] CPU_DI,
    input  logic          CPU_WEn,
    input  logic [BW-1:0] CPU_BEn,
    output logic [DW-1:0] CPU_DO,
    output logic          CPU_READYn,
    input  logic          DMA_REQ,
    input  logic [AW-1:0] DMA_A,
    input  logic [DW-1:0] DMA_DI,
    input  logic          DMA_WE,
    input  logic [BW-1:0] DMA_BEn,
    output logic [DW-1:0] DMA_DO,
    output logic          DMA_ACK,
    output logic [AW-1:0] RAM_A,
    output logic [DW-1:0] RAM_DI,
    input  logic [DW-1:0] RAM_DO,
    output logic          RAM_CEn,
    output logic          RAM_WEn,
    output logic [BW-1:0] RAM_BEn,
    input  logic          RAM_READYn,
    output logic          ERR
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        r_state;
    owner_t        r_owner;
    logic          r_pend;
    logic [CW-1:0] r_tmo;
    logic          r_err;
    logic [DW-1:0] r_cpu_do;
    logic [DW-1:0] r_dma_do;
    logic          r_cpu_readyn;
    logic          r_dma_ack;
    logic [AW-1:0] r_ram_a;
    logic [DW-1:0] r_ram_di;
    logic          r_ram_cen;
    logic          r_ram_wen;
    logic [BW-1:0] r_ram_ben;

    logic          w_start;
    logic          w_req_cpu;
    logic          w_gnt_valid;
    owner_t        w_gnt_owner;
    logic [CW-1:0] w_tmo_next;
    logic          w_tmo_hit;

    assign w_start    = ~CPU_BCYSTn & ~CPU_CEn;
    assign w_req_cpu  = r_pend | w_start;
    assign w_tmo_next = r_tmo + 1'b1;
    assign w_tmo_hit  = (w_tmo_next == CW'(TIMEOUT));

    rr_arb2 u_arb (
        .CLK       (CLK),
        .RESn      (RESn),
        .CE        (CE),
        .i_req_cpu (w_req_cpu),
        .i_req_dma (DMA_REQ),
        .i_take    (r_state == IDLE),
        .o_valid   (w_gnt_valid),
        .o_owner   (w_gnt_owner)
    );

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_state      <= IDLE;
            r_owner      <= OWN_CPU;
            r_pend       <= 1'b0;
            r_tmo        <= '0;
            r_err        <= 1'b0;
            r_cpu_do     <= '0;
            r_dma_do     <= '0;
            r_cpu_readyn <= 1'b1;
            r_dma_ack    <= 1'b0;
            r_ram_a      <= '0;
            r_ram_di     <= '0;
            r_ram_cen    <= 1'b1;
            r_ram_wen    <= 1'b1;
            r_ram_ben    <= '1;
        end else if (CE) begin
            r_cpu_readyn <= 1'b1;
            r_dma_ack    <= 1'b0;
            // A start while already pending collapses into the same flag.
            if (w_start) begin
                r_pend <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner   <= w_gnt_owner;
                        r_state   <= XFER;
                        r_tmo     <= '0;
                        r_ram_cen <= 1'b0;
                        if (w_gnt_owner == OWN_CPU) begin
                            r_pend    <= 1'b0;
                            r_ram_a   <= CPU_A;
                            r_ram_di  <= CPU_DI;
                            r_ram_wen <= CPU_WEn;
                            r_ram_ben <= CPU_BEn;
                        end else begin
                            r_ram_a   <= DMA_A;
                            r_ram_di  <= DMA_DI;
                            r_ram_wen <= ~DMA_WE;
                            r_ram_ben <= DMA_BEn;
                        end
                    end
                end
                XFER: begin
                    r_tmo <= w_tmo_next;
                    if (!RAM_READYn || w_tmo_hit) begin
                        // Ready wins over a coincident timeout; an abort keeps old read data.
                        if (!RAM_READYn) begin
                            if (r_ram_wen) begin
                                if (r_owner == OWN_CPU) begin
                                    r_cpu_do <= RAM_DO;
                                end else begin
                                    r_dma_do <= RAM_DO;
                                end
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_ram_cen <= 1'b1;
                        r_ram_wen <= 1'b1;
                        r_ram_ben <= '1;
                        r_state   <= DONE;
                        if (r_owner == OWN_CPU) begin
                            r_cpu_readyn <= 1'b0;
                        end else begin
                            r_dma_ack <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign CPU_DO     = r_cpu_do;
    assign CPU_READYn = r_cpu_readyn;
    assign DMA_DO     = r_dma_do;
    assign DMA_ACK    = r_dma_ack;
    assign RAM_A      = r_ram_a;
    assign RAM_DI     = r_ram_di;
    assign RAM_CEn    = r_ram_cen;
    assign RAM_WEn    = r_ram_wen;
    assign RAM_BEn    = r_ram_ben;
    assign ERR        = r_err;

endmodule

// File: tb/tb_fx_ram_arb.sv
// Directed bench for fx_ram_arb: a RAM model answers with a per-step latency and a
// scoreboard of expected RAM cycles is checked at cycle start and at completion.
module tb_fx_ram_arb;
    import fx_ram_arb_pkg::*;

    logic        CLK = 1'b0;
    logic        RESn;
    logic        CE;
    logic        CPU_BCYSTn;
    logic        CPU_CEn;
    logic [20:0] CPU_A;
    logic [31:0] CPU_DI;
    logic        CPU_WEn;
    logic [3:0]  CPU_BEn;
    logic [31:0] CPU_DO;
    logic        CPU_READYn;
    logic        DMA_REQ;
    logic [20:0] DMA_A;
    logic [31:0] DMA_DI;
    logic        DMA_WE;
    logic [3:0]  DMA_BEn;
    logic [31:0] DMA_DO;
    logic        DMA_ACK;
    logic [20:0] RAM_A;
    logic [31:0] RAM_DI;
    logic [31:0] RAM_DO;
    logic        RAM_CEn;
    logic        RAM_WEn;
    logic [3:0]  RAM_BEn;
    logic        RAM_READYn = 1'b1;
    logic        ERR;

    always #5 CLK = ~CLK;

    fx_ram_arb #(.TIMEOUT(255)) dut (
        .CLK(CLK), .RESn(RESn), .CE(CE),
        .CPU_BCYSTn(CPU_BCYSTn), .CPU_CEn(CPU_CEn), .CPU_A(CPU_A), .CPU_DI(CPU_DI),
        .CPU_WEn(CPU_WEn), .CPU_BEn(CPU_BEn), .CPU_DO(CPU_DO), .CPU_READYn(CPU_READYn),
        .DMA_REQ(DMA_REQ), .DMA_A(DMA_A), .DMA_DI(DMA_DI), .DMA_WE(DMA_WE),
        .DMA_BEn(DMA_BEn), .DMA_DO(DMA_DO), .DMA_ACK(DMA_ACK),
        .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO), .RAM_CEn(RAM_CEn),
        .RAM_WEn(RAM_WEn), .RAM_BEn(RAM_BEn), .RAM_READYn(RAM_READYn), .ERR(ERR)
    );

    typedef struct {
        bit          dma;
        logic [20:0] a;
        logic [31:0] di;
        bit          we;
        logic [3:0]  ben;
        logic [31:0] exp_do;
        int          cycles;
        bit          err;
    } txn_t;

    txn_t        sb[$];
    logic [31:0] m_cpu_do;
    logic [31:0] m_dma_do;
    bit          m_err;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          n_cmpl   = 0;
    int          ram_lat  = 0;
    int          ce_cnt   = 0;
    bit          prev_cmpl = 1'b0;

    function automatic logic [31:0] ram_func(input logic [20:0] a);
        if (a == 21'h000100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign RAM_DO = ram_func(RAM_A);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit dma, input logic [20:0] a, input logic [31:0] di,
                        input bit we, input logic [3:0] ben, input int cycles, input bit tmo);
        txn_t t;
        if (!we && !tmo) begin
            if (dma) m_dma_do = ram_func(a);
            else     m_cpu_do = ram_func(a);
        end
        if (tmo) m_err = 1'b1;
        t.dma = dma; t.a = a; t.di = di; t.we = we; t.ben = ben;
        t.exp_do = dma ? m_dma_do : m_cpu_do;
        t.cycles = cycles;
        t.err = m_err;
        sb.push_back(t);
    endtask

    // RAM model plus scoreboard monitor, sampled on the falling edge.
    initial forever begin
        txn_t t;
        @(negedge CLK);
        if (!RESn) begin
            ce_cnt = 0;
            prev_cmpl = 1'b0;
            RAM_READYn = 1'b1;
        end else begin
            if (prev_cmpl) chk("pulse_width", {62'b0, CPU_READYn, DMA_ACK}, 64'b10);
            prev_cmpl = 1'b0;
            if (RAM_CEn == 1'b0) begin
                if (ce_cnt == 0 && sb.size() > 0) begin
                    t = sb[0];
                    chk("ram_a",   RAM_A,   t.a);
                    chk("ram_di",  RAM_DI,  t.di);
                    chk("ram_wen", RAM_WEn, !t.we);
                    chk("ram_ben", RAM_BEn, t.ben);
                end
                RAM_READYn = (ram_lat >= 0 && ce_cnt >= ram_lat) ? 1'b0 : 1'b1;
                ce_cnt++;
            end else begin
                RAM_READYn = 1'b1;
                if (!CPU_READYn || DMA_ACK) begin
                    prev_cmpl = 1'b1;
                    n_cmpl++;
                    if (sb.size() == 0) begin
                        chk("spurious_cmpl", {62'b0, ~CPU_READYn, DMA_ACK}, 64'b0);
                    end else begin
                        t = sb.pop_front();
                        chk("owner", {62'b0, ~CPU_READYn, DMA_ACK}, t.dma ? 64'b01 : 64'b10);
                        chk("ce_cycles", ce_cnt, t.cycles);
                        chk(t.dma ? "dma_do" : "cpu_do", t.dma ? DMA_DO : CPU_DO, t.exp_do);
                        chk("err", ERR, t.err);
                        chk("idle_we_be", {RAM_WEn, RAM_BEn}, 64'h1F);
                    end
                end
                ce_cnt = 0;
            end
        end
    end

    task automatic cpu_start(input logic [20:0] a, input logic [31:0] di, input bit we,
                             input logic [3:0] ben);
        CPU_A = a; CPU_DI = di; CPU_WEn = !we; CPU_BEn = ben;
        CPU_BCYSTn = 1'b0; CPU_CEn = 1'b0;
        @(negedge CLK);
        CPU_BCYSTn = 1'b1; CPU_CEn = 1'b1;
    endtask

    task automatic dma_set(input logic [20:0] a, input logic [31:0] di, input bit we,
                           input logic [3:0] ben);
        DMA_A = a; DMA_DI = di; DMA_WE = we; DMA_BEn = ben; DMA_REQ = 1'b1;
    endtask

    task automatic wait_cpu(input int budget, output int n);
        n = 0;
        do begin @(negedge CLK); n++; end while (CPU_READYn && n < budget);
        chk("wait_cpu", CPU_READYn, 1'b0);
    endtask

    task automatic wait_dma(input int budget);
        int n = 0;
        do begin @(negedge CLK); n++; end while (!DMA_ACK && n < budget);
        chk("wait_dma", DMA_ACK, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_readyn"}, CPU_READYn, 1'b1);
        chk({tag, "_dma_ack"},    DMA_ACK,    1'b0);
        chk({tag, "_ram_cen"},    RAM_CEn,    1'b1);
        chk({tag, "_ram_wen"},    RAM_WEn,    1'b1);
        chk({tag, "_ram_ben"},    RAM_BEn,    4'hF);
        chk({tag, "_ram_a"},      RAM_A,      21'h0);
        chk({tag, "_ram_di"},     RAM_DI,     32'h0);
        chk({tag, "_cpu_do"},     CPU_DO,     32'h0);
        chk({tag, "_dma_do"},     DMA_DO,     32'h0);
        chk({tag, "_err"},        ERR,        1'b0);
    endtask

    task automatic apply_reset();
        RESn = 1'b0;
        m_cpu_do = '0; m_dma_do = '0; m_err = 1'b0;
        repeat (2) @(negedge CLK);
        RESn = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        int n;
        RESn = 1'b0; CE = 1'b1;
        CPU_BCYSTn = 1'b1; CPU_CEn = 1'b1; CPU_A = '0; CPU_DI = '0; CPU_WEn = 1'b1; CPU_BEn = 4'hF;
        DMA_REQ = 1'b0; DMA_A = '0; DMA_DI = '0; DMA_WE = 1'b0; DMA_BEn = 4'hF;
        m_cpu_do = '0; m_dma_do = '0; m_err = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_outputs("por");
        RESn = 1'b1;
        @(negedge CLK);

        // CPU read, ready on the first XFER cycle
        ram_lat = 0;
        push(0, 21'h000100, 32'h0, 0, 4'h0, 1, 0);
        cpu_start(21'h000100, 32'h0, 0, 4'h0);
        wait_cpu(20, n);
        chk("cpu_latency", n, 1);

        // CPU write, two wait states; CPU_DO holds
        ram_lat = 2;
        push(0, 21'h000204, 32'hAABBCCDD, 1, 4'b0011, 3, 0);
        cpu_start(21'h000204, 32'hAABBCCDD, 1, 4'b0011);
        wait_cpu(20, n);

        // DMA read, one wait state
        ram_lat = 1;
        push(1, 21'h000200, 32'h11111111, 0, 4'h0, 2, 0);
        dma_set(21'h000200, 32'h11111111, 0, 4'h0);
        wait_dma(20);
        DMA_REQ = 1'b0;

        // DMA write at top of address space; DMA_DO holds
        ram_lat = 0;
        push(1, 21'h1FFFFC, 32'h12345678, 1, 4'b1100, 1, 0);
        dma_set(21'h1FFFFC, 32'h12345678, 1, 4'b1100);
        wait_dma(20);
        DMA_REQ = 1'b0;

        // CE held low for three cycles inside XFER stretches the RAM cycle
        push(1, 21'h000300, 32'h0, 0, 4'h0, 4, 0);
        dma_set(21'h000300, 32'h0, 0, 4'h0);
        n = 0;
        do begin @(negedge CLK); n++; end while (RAM_CEn && n < 20);
        chk("wait_ram_cen", RAM_CEn, 1'b0);
        CE = 1'b0;
        repeat (3) @(negedge CLK);
        CE = 1'b1;
        wait_dma(20);
        DMA_REQ = 1'b0;

        // Tie after reset: CPU first, then DMA once
        apply_reset();
        push(0, 21'h000400, 32'h0, 0, 4'h0, 1, 0);
        push(1, 21'h000500, 32'h0, 0, 4'h0, 1, 0);
        dma_set(21'h000500, 32'h0, 0, 4'h0);
        cpu_start(21'h000400, 32'h0, 0, 4'h0);
        wait_cpu(20, n);
        wait_dma(20);
        DMA_REQ = 1'b0;
        repeat (6) @(negedge CLK);
        chk("tie_sb_empty", sb.size(), 0);

        // DMA held high, CPU restarts at each CPU completion: grants alternate
        push(0, 21'h000600, 32'h0, 0, 4'h0, 1, 0);
        push(1, 21'h000700, 32'h0, 0, 4'h0, 1, 0);
        push(0, 21'h000604, 32'h0, 0, 4'h0, 1, 0);
        push(1, 21'h000700, 32'h0, 0, 4'h0, 1, 0);
        push(0, 21'h000608, 32'h0, 0, 4'h0, 1, 0);
        push(1, 21'h000700, 32'h0, 0, 4'h0, 1, 0);
        dma_set(21'h000700, 32'h0, 0, 4'h0);
        cpu_start(21'h000600, 32'h0, 0, 4'h0);
        wait_cpu(20, n);
        cpu_start(21'h000604, 32'h0, 0, 4'h0);
        wait_dma(20);
        cpu_start(21'h000604, 32'h0, 0, 4'h0);
        wait_cpu(20, n);
        cpu_start(21'h000608, 32'h0, 0, 4'h0);
        wait_cpu(20, n);
        wait_dma(20);
        DMA_REQ = 1'b0;
        repeat (6) @(negedge CLK);
        chk("rr_sb_empty", sb.size(), 0);

        // RAM never ready: abort after 255 XFER cycles, ERR sticky
        ram_lat = -1;
        push(0, 21'h000800, 32'h0, 0, 4'h0, 255, 1);
        cpu_start(21'h000800, 32'h0, 0, 4'h0);
        wait_cpu(300, n);
        ram_lat = 0;
        @(negedge CLK);
        chk("err_set", ERR, 1'b1);
        push(1, 21'h000900, 32'h0, 0, 4'h0, 1, 0);
        dma_set(21'h000900, 32'h0, 0, 4'h0);
        wait_dma(20);
        DMA_REQ = 1'b0;
        repeat (5) @(negedge CLK);
        chk("err_sticky", ERR, 1'b1);

        // Reset mid-XFER abandons the cycle with no completion
        ram_lat = -1;
        cpu_start(21'h000A00, 32'h0, 0, 4'h0);
        repeat (4) @(negedge CLK);
        chk("xfer_active", RAM_CEn, 1'b0);
        #2 RESn = 1'b0;
        m_cpu_do = '0; m_dma_do = '0; m_err = 1'b0;
        #1 chk_reset_outputs("mid");
        repeat (3) @(negedge CLK);
        ram_lat = 0;
        RESn = 1'b1;
        repeat (6) @(negedge CLK);
        push(0, 21'h000B00, 32'h0, 0, 4'h0, 1, 0);
        push(1, 21'h000B04, 32'h0, 0, 4'h0, 1, 0);
        dma_set(21'h000B04, 32'h0, 0, 4'h0);
        cpu_start(21'h000B00, 32'h0, 0, 4'h0);
        wait_cpu(20, n);
        wait_dma(20);
        DMA_REQ = 1'b0;
        repeat (6) @(negedge CLK);
        chk("final_sb_empty", sb.size(), 0);
        chk("cmpl_count", n_cmpl, 17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fx_ram_arb.md
FX_RAM_ARB -- requirements
Module: fx_ram_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of CE cycles spent in XFER before a cycle is aborted.
REQ-002 SHALL have ports (clock and reset first):
- CLK  in  1  system clock; single clock domain.
- RESn  in  1  reset; asynchronous, active-low.
- CE  in  1  clock enable; all state advances only on CLK edges with CE=1.
- CPU_BCYSTn  in  1  CPU bus-cycle start strobe, active-low, one CE cycle.
- CPU_CEn  in  1  RAM chip-select decode for the current CPU cycle, active-low.
- CPU_A  in  21  CPU byte address.
- CPU_DI  in  32  CPU write data.
- CPU_WEn  in  1  CPU write, active-low.
- CPU_BEn  in  4  CPU byte enables, active-low.
- CPU_DO  out  32  CPU read data.
- CPU_READYn  out  1  CPU cycle completion, active-low.
- DMA_REQ  in  1  DMA request level.
- DMA_A  in  21  DMA byte address.
- DMA_DI  in  32  DMA write data.
- DMA_WE  in  1  DMA write, active-high.
- DMA_BEn  in  4  DMA byte enables, active-low.
- DMA_DO  out  32  DMA read data.
- DMA_ACK  out  1  DMA completion pulse.
- RAM_A  out  21  RAM byte address.
- RAM_DI  out  32  RAM write data.
- RAM_DO  in  32  RAM read data.
- RAM_CEn  out  1  RAM select, active-low.
- RAM_WEn  out  1  RAM write, active-low.
- RAM_BEn  out  4  RAM byte enables, active-low.
- RAM_READYn  in  1  RAM completion, active-low.
- ERR  out  1  sticky timeout flag.

Function
REQ-003 SHALL set a CPU-pending flag when CPU_BCYSTn=0 and CPU_CEn=0 on a CE cycle. The flag clears when the CPU grant is issued.
REQ-004 SHALL implement an FSM with states IDLE, XFER, DONE. The state changes only on CE cycles.
REQ-005 IDLE: grant selection.
- A CPU request is the pending flag OR the start condition in the same cycle.
- A DMA request is DMA_REQ=1.
- If exactly one requester is active, it is granted.
- If both are active, the grant goes to the requester not granted last (round-robin). The last-grant register resets to DMA, so CPU wins the first tie.
- On a grant, the FSM moves to XFER.
REQ-006 On a grant, SHALL register the owner's address, data, write and byte enables onto RAM_A/RAM_DI/RAM_WEn/RAM_BEn and drive RAM_CEn=0 for the whole of XFER. These outputs hold stable until XFER exits.
REQ-007 XFER: on each CE cycle, SHALL sample RAM_READYn.
- If RAM_READYn=0: capture RAM_DO into CPU_DO or DMA_DO (owner only; on writes the register holds its old value), set RAM_CEn=1, and move to DONE.
REQ-008 DONE lasts exactly one CE cycle, then the FSM moves to IDLE.
- CPU owner: CPU_READYn=0 for that one cycle.
- DMA owner: DMA_ACK=1 for that one cycle.
REQ-009 Minimum latency: grant at CE edge t0, RAM_READYn sampled low at t1, completion visible between t1 and t2, IDLE at t2. Back-to-back grants are therefore spaced 3 CE cycles apart.
REQ-010 A timeout counter SHALL clear on entry to XFER and increment each CE cycle in XFER. When it reaches TIMEOUT:
- set ERR=1 (sticky until reset);
- set RAM_CEn=1 and go to DONE, still issuing the owner's completion;
- leave the owner's read data register unchanged.
REQ-011 DMA_REQ still high in IDLE after DMA_ACK SHALL be treated as a new request.
REQ-012 A CPU start arriving during XFER or DONE of a DMA cycle SHALL be held in the pending flag and not lost. A second start while already pending SHALL be ignored.
REQ-013 DMA_REQ dropping during XFER SHALL NOT abort the RAM cycle; DMA_ACK is still issued.
REQ-014 Outside XFER: RAM_CEn=1, RAM_WEn=1, RAM_BEn=4'hF.

Reset
REQ-015 While RESn=0, regardless of CLK or CE, SHALL force:
- FSM=IDLE; pending flag=0; last-grant=DMA; timeout counter=0; ERR=0;
- CPU_READYn=1, DMA_ACK=0;
- RAM_CEn=1, RAM_WEn=1, RAM_BEn=4'hF, RAM_A=0, RAM_DI=0;
- CPU_DO=0, DMA_DO=0.
REQ-016 Reset asserted mid-XFER SHALL abandon the cycle with no completion pulse. After release, arbitration restarts from REQ-015 state.

Structure
REQ-017 A shared package fx_ram_arb_pkg SHALL hold:
- the state enum (IDLE, XFER, DONE);
- the owner enum (OWN_CPU, OWN_DMA);
- the default TIMEOUT constant.
REQ-018 The block SHALL use one sub-module, rr_arb2: a two-input round-robin grant with a last-grant register. All other logic is inline.

Verification
REQ-019 CPU read at 0x000100, RAM_READYn low on the first XFER cycle, RAM_DO=0xDEADBEEF -> RAM_CEn low for 1 CE cycle, CPU_DO=0xDEADBEEF, CPU_READYn low exactly 1 CE cycle, t2-t0=2.
REQ-020 CPU start and DMA_REQ in the same cycle after reset -> CPU granted first, DMA granted at the next IDLE, DMA_ACK pulses once.
REQ-021 DMA_REQ held continuously with a CPU start every DONE -> grants alternate CPU/DMA/CPU/DMA, and no CPU start is dropped.
REQ-022 DMA write to 0x1FFFFC with DMA_BEn=4'b1100 -> RAM_A=0x1FFFFC, RAM_WEn=0, RAM_BEn=4'b1100, DMA_DO unchanged.
REQ-023 RAM_READYn held high -> after 255 CE cycles in XFER: ERR=1, RAM_CEn=1, CPU_READYn pulses once, ERR remains 1 until RESn.
REQ-024 RESn asserted during XFER -> all outputs take REQ-015 values immediately, with no CPU_READYn/DMA_ACK pulse.
